// File: rtl/lamp_fpu_i2f_arbiter.sv
// Round-robin arbiter sharing one lampFPU i2f converter among NUM_REQ
// requesters: valid/ready request ports in, raw i2f result returned to owner.
//
// Ports: clk, rst_n (async, active low)
//   req_valid_i/req_op_i/req_ready_o     per-requester request handshake
//   rsp_valid_o/rsp_ready_i              per-requester response handshake
//   rsp_s/e/f/isToRound/isOvf/isUnf_o    shared captured-result bus
//   i2f_do_o/i2f_op1_o                   converter issue
//   i2f_valid_i, i2f_*_i                 converter result
//   err_spurious_o                       sticky: result seen outside WAIT

package lampFPU_pkg;
  localparam int LAMP_INTEGER_DW = 32;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
endpackage

module lamp_fpu_i2f_arbiter
  import lampFPU_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*LAMP_INTEGER_DW-1:0] req_op_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic                         rsp_s_o,
  output logic [LAMP_FLOAT_E_DW-1:0]   rsp_e_o,
  output logic [LAMP_FLOAT_F_DW+4:0]   rsp_f_o,
  output logic                         rsp_isToRound_o,
  output logic                         rsp_isOvf_o,
  output logic                         rsp_isUnf_o,
  output logic                         i2f_do_o,
  output logic [LAMP_INTEGER_DW-1:0]   i2f_op1_o,
  input  logic                         i2f_valid_i,
  input  logic                         i2f_s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]   i2f_e_i,
  input  logic [LAMP_FLOAT_F_DW+4:0]   i2f_f_i,
  input  logic                         i2f_isToRound_i,
  input  logic                         i2f_isOvf_i,
  input  logic                         i2f_isUnf_i,
  output logic                         err_spurious_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int W = LAMP_INTEGER_DW;

  typedef enum logic [1:0] {
    ARB, ISSUE, WAIT, RESP
  } state_t;

  state_t state, stateNxt;

  logic [ID_W-1:0] rrPtr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            accept;
  logic            capture;
  logic [W-1:0]    opQ;

  logic                       resS;
  logic [LAMP_FLOAT_E_DW-1:0] resE;
  logic [LAMP_FLOAT_F_DW+4:0] resF;
  logic                       resRnd;
  logic                       resOvf;
  logic                       resUnf;
  logic                       errQ;

  // Circular search starting at rrPtr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rrPtr) + i) % NUM_REQ;
      if (!found && req_valid_i[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign accept  = (state == ARB) && found;
  assign capture = (state == WAIT) && i2f_valid_i;

  always_comb begin
    stateNxt    = state;
    i2f_do_o    = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    unique case (state)
      ARB: begin
        if (found) begin
          req_ready_o[grant] = 1'b1;
          stateNxt = ISSUE;
        end
      end
      ISSUE: begin
        i2f_do_o = 1'b1;
        stateNxt = WAIT;
      end
      WAIT: begin
        if (i2f_valid_i) stateNxt = RESP;
      end
      RESP: begin
        rsp_valid_o[owner] = 1'b1;
        if (rsp_ready_i[owner]) stateNxt = ARB;
      end
      default: stateNxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= stateNxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= '0;
      owner <= '0;
      opQ   <= '0;
    end else if (accept) begin
      opQ   <= req_op_i[int'(grant)*W +: W];
      owner <= grant;
      rrPtr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resS   <= 1'b0;
      resE   <= '0;
      resF   <= '0;
      resRnd <= 1'b0;
      resOvf <= 1'b0;
      resUnf <= 1'b0;
    end else if (capture) begin
      resS   <= i2f_s_i;
      resE   <= i2f_e_i;
      resF   <= i2f_f_i;
      resRnd <= i2f_isToRound_i;
      resOvf <= i2f_isOvf_i;
      resUnf <= i2f_isUnf_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errQ <= 1'b0;
    else if (i2f_valid_i && state != WAIT) errQ <= 1'b1;
  end

  assign i2f_op1_o       = opQ;
  assign rsp_s_o         = resS;
  assign rsp_e_o         = resE;
  assign rsp_f_o         = resF;
  assign rsp_isToRound_o = resRnd;
  assign rsp_isOvf_o     = resOvf;
  assign rsp_isUnf_o     = resUnf;
  assign err_spurious_o  = errQ;

endmodule

// File: tb/tb_lamp_fpu_i2f_arbiter.sv
// Self-checking bench for lamp_fpu_i2f_arbiter with a 1-cycle
// stand-in converter and a round-robin reference model.
module tb_lamp_fpu_i2f_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_op;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic         rsp_s;
  logic [7:0]   rsp_e;
  logic [11:0]  rsp_f;
  logic         rsp_rnd, rsp_ovf, rsp_unf;
  logic         i2f_do;
  logic [31:0]  i2f_op1;
  logic         i2f_valid, i2f_s;
  logic [7:0]   i2f_e;
  logic [11:0]  i2f_f;
  logic         i2f_rnd, i2f_ovf, i2f_unf;
  logic         err;

  int errors = 0;
  int checks = 0;
  int modelPtr = 0;
  bit convStall = 0;

  logic [23:0] rspBus;
  logic [65:0] allOut;
  assign rspBus = {rsp_s, rsp_e, rsp_f, rsp_rnd, rsp_ovf, rsp_unf};
  assign allOut = {req_ready, rsp_valid, rspBus, i2f_do, i2f_op1, err};

  lamp_fpu_i2f_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_s_o(rsp_s), .rsp_e_o(rsp_e), .rsp_f_o(rsp_f),
    .rsp_isToRound_o(rsp_rnd), .rsp_isOvf_o(rsp_ovf),
    .rsp_isUnf_o(rsp_unf),
    .i2f_do_o(i2f_do), .i2f_op1_o(i2f_op1),
    .i2f_valid_i(i2f_valid), .i2f_s_i(i2f_s),
    .i2f_e_i(i2f_e), .i2f_f_i(i2f_f),
    .i2f_isToRound_i(i2f_rnd), .i2f_isOvf_i(i2f_ovf),
    .i2f_isUnf_i(i2f_unf),
    .err_spurious_o(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Stand-in converter: sign/exponent/normalised fraction; flags from op bits.
  function automatic logic [23:0] conv(input logic [31:0] op);
    logic [31:0] mag;
    logic [31:0] norm;
    int p;
    if (op == 32'd0) return 24'h0;
    mag = op[31] ? -op : op;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    norm = mag << (31 - p);
    return {op[31], 8'(127 + p), norm[31:20], 1'b1, op[1], op[2]};
  endfunction

  function automatic int modelGrant(input logic [3:0] m);
    for (int i = 0; i < N; i++)
      if (m[(modelPtr + i) % N]) return (modelPtr + i) % N;
    return -1;
  endfunction

  initial begin
    logic        pendDo;
    logic [31:0] pendOp;
    logic        newDo;
    logic [31:0] newOp;
    pendDo = 0;
    pendOp = 0;
    i2f_valid = 0;
    {i2f_s, i2f_e, i2f_f, i2f_rnd, i2f_ovf, i2f_unf} = '0;
    forever begin
      @(posedge clk);
      #1;
      newDo = i2f_do;
      newOp = i2f_op1;
      if (convStall) begin
        i2f_valid = 0;
        if (newDo) begin
          pendDo = 1;
          pendOp = newOp;
        end
      end else begin
        i2f_valid = pendDo;
        {i2f_s, i2f_e, i2f_f, i2f_rnd, i2f_ovf, i2f_unf} = conv(pendOp);
        pendDo = newDo;
        pendOp = newOp;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL reset_during got=%h want=0", allOut);
    end
    tick();
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL reset_after got=%h want=0", allOut);
    end
  endtask

  task automatic test_round_robin(input int n, input bit rnd);
    int order [5];
    logic [31:0] ops [4];
    logic [3:0] mask;
    int g;
    bit seen;
    order = '{0, 1, 2, 3, 0};
    for (int t = 0; t < n; t++) begin
      mask = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
      for (int k = 0; k < N; k++) begin
        ops[k] = rnd ? $urandom : 32'(k + 1);
        req_op[k*32 +: 32] = ops[k];
      end
      req_valid = mask;
      #1;
      g = rnd ? modelGrant(mask) : order[t % 5];
      checks++;
      if (req_ready !== 4'(1 << g)) begin
        errors++;
        $display("FAIL rr_grant t=%0d got=%b want=%b",
                 t, req_ready, 4'(1 << g));
      end
      tick();
      req_valid = 0;
      checks++;
      if (i2f_do !== 1'b1 || i2f_op1 !== ops[g]) begin
        errors++;
        $display("FAIL rr_issue t=%0d do=%b op=%h want op=%h",
                 t, i2f_do, i2f_op1, ops[g]);
      end
      rsp_ready = rnd ? (4'($urandom) & ~4'(1 << g)) : 4'hF;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        tick();
        seen = (rsp_valid !== 4'b0);
      end
      checks++;
      if (rsp_valid !== 4'(1 << g) || rspBus !== conv(ops[g])) begin
        errors++;
        $display("FAIL rr_rsp t=%0d vld=%b bus=%h want vld=%b bus=%h",
                 t, rsp_valid, rspBus, 4'(1 << g), conv(ops[g]));
      end
      if (rnd) begin
        repeat ($urandom_range(0, 3)) tick();
        checks++;
        if (rsp_valid !== 4'(1 << g) || rspBus !== conv(ops[g])) begin
          errors++;
          $display("FAIL rr_hold t=%0d vld=%b bus=%h want vld=%b bus=%h",
                   t, rsp_valid, rspBus, 4'(1 << g), conv(ops[g]));
        end
        rsp_ready = rsp_ready | 4'(1 << g);
      end
      tick();
      rsp_ready = rnd ? 4'h0 : 4'hF;
      checks++;
      if (rsp_valid !== 4'b0) begin
        errors++;
        $display("FAIL rr_release t=%0d vld=%b want=0", t, rsp_valid);
      end
      modelPtr = (g + 1) % N;
    end
    rsp_ready = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rr_no_spurious err=%b want=0", err);
    end
  endtask

  task automatic test_latency;
    req_op[31:0] = 32'd1;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lat_ready got=%b want=0001", req_ready);
    end
    tick();
    req_valid = 0;
    checks++;
    if (i2f_do !== 1'b1 || i2f_op1 !== 32'd1) begin
      errors++;
      $display("FAIL lat_issue do=%b op=%h want 1/1", i2f_do, i2f_op1);
    end
    tick();
    checks++;
    if (i2f_do !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL lat_wait do=%b vld=%b want 0/0", i2f_do, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL lat_rsp_valid got=%b want=0001", rsp_valid);
    end
    checks++;
    if ({rsp_s, rsp_e, rsp_rnd} !== {1'b0, 8'h7F, 1'b1} ||
        rspBus !== conv(32'd1)) begin
      errors++;
      $display("FAIL lat_rsp_data got=%h want=%h", rspBus, conv(32'd1));
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL lat_done vld=%b want=0", rsp_valid);
    end
    modelPtr = 1;
  endtask

  task automatic test_backpressure;
    logic [31:0] op;
    bit stable;
    op = $urandom;
    req_op[31:0] = op;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 0;
    modelPtr = 1;
    for (int i = 0; i < 8 && rsp_valid === 4'b0; i++) tick();
    checks++;
    if (rsp_valid !== 4'b0001 || rspBus !== conv(op)) begin
      errors++;
      $display("FAIL bp_rsp vld=%b bus=%h want 0001/%h",
               rsp_valid, rspBus, conv(op));
    end
    rsp_ready = 4'b1110;
    req_valid = 4'hF;
    stable = 1;
    repeat (10) begin
      tick();
      if (rsp_valid !== 4'b0001 || rspBus !== conv(op) ||
          req_ready !== 4'b0 || i2f_do !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold vld=%b bus=%h rdy=%b do=%b want 0001/%h/0/0",
               rsp_valid, rspBus, req_ready, i2f_do, conv(op));
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 0;
    checks++;
    if (req_ready !== 4'(1 << modelGrant(4'hF))) begin
      errors++;
      $display("FAIL bp_release rdy=%b want=%b",
               req_ready, 4'(1 << modelGrant(4'hF)));
    end
    req_valid = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL bp_idle rdy=%b want=0", req_ready);
    end
  endtask

  task automatic test_edge_values;
    logic [31:0] vals [3];
    int id;
    vals = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int v = 0; v < 3; v++) begin
      id = v + 1;
      req_op[id*32 +: 32] = vals[v];
      req_valid = 4'(1 << id);
      #1;
      tick();
      req_valid = 0;
      for (int i = 0; i < 8 && rsp_valid === 4'b0; i++) tick();
      checks++;
      if (rsp_valid !== 4'(1 << id) || rspBus !== conv(vals[v])) begin
        errors++;
        $display("FAIL edge_rsp v=%h vld=%b bus=%h want %b/%h", vals[v],
                 rsp_valid, rspBus, 4'(1 << id), conv(vals[v]));
      end
      if (v == 0) begin
        checks++;
        if (rspBus !== 24'h0) begin
          errors++;
          $display("FAIL edge_zero bus=%h want=0", rspBus);
        end
      end
      if (v == 1) begin
        checks++;
        if (rsp_s !== 1'b1 || rsp_e !== 8'h7F) begin
          errors++;
          $display("FAIL edge_neg1 s=%b e=%h want 1/7f", rsp_s, rsp_e);
        end
      end
      rsp_ready = 4'(1 << id);
      tick();
      rsp_ready = 0;
      modelPtr = (id + 1) % N;
    end
  endtask

  task automatic test_drop;
    bit idle;
    req_op[63:32] = $urandom;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 0;
    rsp_ready = 4'b0010;
    for (int i = 0; i < 8 && rsp_valid === 4'b0; i++) tick();
    tick();
    rsp_ready = 0;
    modelPtr = 2;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL drop_req3_first rdy=%b want=1000", req_ready);
    end
    tick();
    req_valid = 0;
    rsp_ready = 4'b1000;
    for (int i = 0; i < 8 && rsp_valid === 4'b0; i++) tick();
    checks++;
    if (rsp_valid !== 4'b1000) begin
      errors++;
      $display("FAIL drop_rsp3 vld=%b want=1000", rsp_valid);
    end
    tick();
    rsp_ready = 0;
    modelPtr = 0;
    idle = 1;
    repeat (4) begin
      if (req_ready !== 0 || i2f_do !== 0 || rsp_valid !== 0) idle = 0;
      tick();
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drop_idle rdy=%b do=%b vld=%b want 0",
               req_ready, i2f_do, rsp_valid);
    end
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL drop_no_hang rdy=%b want=0010", req_ready);
    end
    req_valid = 0;
  endtask

  task automatic test_reset_midop;
    convStall = 1;
    req_op[127:96] = $urandom;
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%h want=0", allOut);
    end
    tick();
    rst_n = 1;
    convStall = 0;
    modelPtr = 0;
    repeat (3) tick();
    checks++;
    if (err !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL rst_late_spurious err=%b vld=%b want 1/0",
               err, rsp_valid);
    end
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_restart_ptr0 rdy=%b want=0001", req_ready);
    end
    req_valid = 0;
  endtask

  initial begin
    rst_n = 1;
    req_valid = 0;
    req_op = '0;
    rsp_ready = 0;
    #1;
    rst_n = 0;
    test_reset();
    test_round_robin(5, 1'b0);
    test_latency();
    test_round_robin(40, 1'b1);
    test_backpressure();
    test_edge_values();
    test_drop();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
